// File: rtl/mem_pkg.sv
// Shared definitions for the memory access controller.
//   DATA_W  : memory data width
//   size_e  : request size encoding (byte / half / word / illegal)
//   state_e : controller FSM states
package mem_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    WR,
    RESP
  } state_e;

endpackage

// File: rtl/mem_lane_format.sv
// Combinational lane formatter for sub-word accesses.
//   rd          : word read from memory
//   wdata       : right-justified store data
//   offset      : byte offset within the word (addr[1:0])
//   size        : access size (mem_pkg::size_e encoding)
//   is_unsigned : loads only, 1 = zero-extend
//   load_data   : extracted and extended load value
//   store_word  : rd with the target lane replaced by wdata
module mem_lane_format
  import mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [DATA_W-1:0] rd,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] store_word
);

  logic [4:0]        shamt;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] lane;

  always_comb begin
    shamt     = 5'd0;
    lane_mask = '1;
    unique case (size)
      SZ_BYTE: begin
        lane_mask = 32'h0000_00ff;
        // Big-endian: offset 0 sits in the top byte, so shift = (3 - offset) * 8.
        shamt     = BIG_ENDIAN ? {~offset, 3'b000} : {offset, 3'b000};
      end
      SZ_HALF: begin
        lane_mask = 32'h0000_ffff;
        shamt     = BIG_ENDIAN ? {~offset[1], 4'b0000} : {offset[1], 4'b0000};
      end
      default: begin
        lane_mask = '1;
        shamt     = 5'd0;
      end
    endcase
  end

  assign lane = rd >> shamt;

  always_comb begin
    load_data = lane;
    unique case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & lane[7]}}, lane[7:0]};
      SZ_HALF: load_data = {{16{~is_unsigned & lane[15]}}, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  // Only the target lane changes; every other lane keeps the value just read.
  assign store_word = (rd & ~(lane_mask << shamt)) | ((wdata & lane_mask) << shamt);

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for a word-addressed, synchronous-read memory.
// Accepts byte/half/word loads and stores over a valid/ready handshake,
// performs sub-word stores as read-modify-write and rejects misaligned,
// out-of-range or illegal-size requests without touching memory.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_we, req_size, req_unsigned, req_addr, req_wdata : request fields
//   resp_valid          : one-cycle completion pulse
//   resp_rdata          : formatted load data (0 for stores and errors)
//   resp_err            : request was rejected
//   Adr, WE, WD         : registered memory address / write enable / write data
//   RD                  : memory read data, valid the cycle after Adr is presented
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 512,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [31:0]       Adr,
  output logic              WE,
  output logic [DATA_W-1:0] WD,
  input  logic [DATA_W-1:0] RD
);

  state_e            state_q, state_d;
  logic              st_we_q, st_we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        off_q, off_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [31:0]       adr_q, adr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] store_word;
  logic [31:0]       req_widx;
  logic              req_err;

  mem_lane_format #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_lane_format (
    .rd         (RD),
    .wdata      (wdata_q),
    .offset     (off_q),
    .size       (size_q),
    .is_unsigned(uns_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  assign req_widx = {2'b00, req_addr[31:2]};

  always_comb begin
    req_err = 1'b0;
    unique case (req_size)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = req_addr[0];
      SZ_WORD: req_err = (req_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
    if (req_widx >= MEM_WORDS) begin
      req_err = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    st_we_d  = st_we_q;
    size_d   = size_q;
    uns_d    = uns_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    adr_d    = adr_q;
    wd_d     = wd_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    // WE is a single-cycle pulse; it is only raised on entry to WR.
    mem_we_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          st_we_d = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          off_d   = req_addr[1:0];
          wdata_d = req_wdata;
          adr_d   = {req_addr[31:2], 2'b00};
          rdata_d = '0;
          err_d   = req_err;
          if (req_err) begin
            state_d = RESP;
          end else if (req_we && (req_size == SZ_WORD)) begin
            mem_we_d = 1'b1;
            wd_d     = req_wdata;
            state_d  = WR;
          end else begin
            state_d = RD1;
          end
        end
      end
      RD1: begin
        state_d = RD2;
      end
      RD2: begin
        if (st_we_q) begin
          wd_d     = store_word;
          mem_we_d = 1'b1;
          state_d  = WR;
        end else begin
          rdata_d = load_data;
          state_d = RESP;
        end
      end
      WR: begin
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      st_we_q  <= 1'b0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      off_q    <= 2'b00;
      wdata_q  <= '0;
      adr_q    <= '0;
      mem_we_q <= 1'b0;
      wd_q     <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      st_we_q  <= st_we_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      adr_q    <= adr_d;
      mem_we_q <= mem_we_d;
      wd_q     <= wd_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign Adr        = adr_q;
  assign WE         = mem_we_q;
  assign WD         = wd_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int unsigned MEM_WORDS  = 512;
  localparam bit          BIG_ENDIAN = 1'b1;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] Adr;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;

  int errors;
  int checks;

  mem_access_ctrl #(
    .MEM_WORDS (MEM_WORDS),
    .BIG_ENDIAN(BIG_ENDIAN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .Adr         (Adr),
    .WE          (WE),
    .WD          (WD),
    .RD          (RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached memory with a backdoor for preloading.
  logic [31:0] mem     [0:MEM_WORDS-1];
  logic [31:0] ref_mem [0:MEM_WORDS-1];
  logic        bd_clear;
  logic        bd_we;
  logic [8:0]  bd_idx;
  logic [31:0] bd_data;

  always @(posedge clk) begin
    if (bd_clear) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'h0;
    end else if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end else if (WE) begin
      mem[Adr[10:2]] <= WD;
    end
    RD <= mem[Adr[10:2]];
  end

  task automatic preload(input int idx, input logic [31:0] data);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx[8:0]; bd_data = data;
    @(posedge clk); #1 bd_we = 1'b0;
    ref_mem[idx] = data;
  endtask

  // Byte a (0..3) of a word, as seen in memory byte order.
  function automatic logic [7:0] byte_at(input logic [31:0] w, input int a);
    int pos;
    pos = BIG_ENDIAN ? (3 - a) * 8 : a * 8;
    return 8'((w >> pos) & 32'hff);
  endfunction

  // Reference model: byte-by-byte view of memory; updates ref_mem on stores.
  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] e_rdata, output logic e_err,
                                output int e_lat, output int e_we, output logic [31:0] e_wd);
    int nb, off;
    logic [31:0] widx, w, val;
    logic [7:0] b;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    widx = addr >> 2;
    e_rdata = 32'h0; e_we = 0; e_wd = 32'h0;
    e_err = (nb == 0) || ((addr % nb) != 0) || (widx >= MEM_WORDS);
    if (e_err) begin
      e_lat = 1;
      return;
    end
    off = int'(addr % 4);
    w = ref_mem[widx];
    if (!we) begin
      val = 32'h0;
      for (int i = 0; i < nb; i++) begin
        b = byte_at(w, off + i);
        if (BIG_ENDIAN) val = (val << 8) | {24'h0, b};
        else val = val | ({24'h0, b} << (8 * i));
      end
      if (!uns && nb < 4 && val[8 * nb - 1]) val = val | ~((32'h1 << (8 * nb)) - 1);
      e_rdata = val;
      e_lat = 3;
    end else begin
      for (int i = 0; i < nb; i++) begin
        int pos;
        int sel;
        sel = BIG_ENDIAN ? (nb - 1 - i) : i;
        b = 8'((wdata >> (8 * sel)) & 32'hff);
        pos = BIG_ENDIAN ? (3 - (off + i)) * 8 : (off + i) * 8;
        w = (w & ~(32'hff << pos)) | ({24'h0, b} << pos);
      end
      ref_mem[widx] = w;
      e_wd = w;
      e_we = 1;
      e_lat = (nb == 4) ? 2 : 4;
    end
  endfunction

  // Issue one request and observe it until resp_valid (bounded).
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output logic [31:0] rdata, output logic err,
                       output int we_cnt, output logic [31:0] wd_seen);
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0; rdata = 32'h0; err = 1'b0; we_cnt = 0; wd_seen = 32'h0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (WE === 1'b1) begin
        we_cnt++;
        wd_seen = WD;
      end
      if (resp_valid === 1'b1) begin
        lat = k; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
    checks++; if (Adr !== 32'h0) begin errors++; $display("FAIL reset_adr got=%h exp=0", Adr); end
    checks++; if (WE !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", WE); end
    checks++; if (WD !== 32'h0) begin errors++; $display("FAIL reset_wd got=%h exp=0", WD); end
    @(negedge clk); bd_clear = 1'b1;
    @(negedge clk); bd_clear = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'h0;
  endtask

  task automatic test_word_load();
    int lat, wec, elat, ewe; logic [31:0] rd, wds, erd, ewd; logic er, eer;
    preload(4, 32'h1122_3344);
    model(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, erd, eer, elat, ewe, ewd);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, wec, wds);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wload_lat got=%0d exp=3", lat); end
    checks++; if (rd !== 32'h1122_3344) begin errors++; $display("FAIL wload_data got=%h exp=11223344", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wload_err got=%b exp=0", er); end
    checks++; if (wec !== 0) begin errors++; $display("FAIL wload_we got=%0d exp=0", wec); end
  endtask

  task automatic test_byte_store();
    int lat, wec, elat, ewe; logic [31:0] rd, wds, erd, ewd; logic er, eer;
    model(1'b1, 2'b00, 1'b0, 32'h12, 32'hab, erd, eer, elat, ewe, ewd);
    issue(1'b1, 2'b00, 1'b0, 32'h12, 32'hab, lat, rd, er, wec, wds);
    checks++; if (lat !== 4) begin errors++; $display("FAIL bstore_lat got=%0d exp=4", lat); end
    checks++; if (wec !== 1) begin errors++; $display("FAIL bstore_we got=%0d exp=1", wec); end
    checks++; if (wds !== 32'h1122_ab44) begin errors++; $display("FAIL bstore_wd got=%h exp=1122ab44", wds); end
    model(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, erd, eer, elat, ewe, ewd);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, wec, wds);
    checks++; if (rd !== 32'h1122_ab44) begin errors++; $display("FAIL bstore_readback got=%h exp=1122ab44", rd); end
  endtask

  task automatic test_sign_ext();
    int lat, wec, elat, ewe; logic [31:0] rd, wds, erd, ewd; logic er, eer;
    model(1'b1, 2'b00, 1'b0, 32'h13, 32'h80, erd, eer, elat, ewe, ewd);
    issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h80, lat, rd, er, wec, wds);
    model(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, erd, eer, elat, ewe, ewd);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rd, er, wec, wds);
    checks++; if (rd !== 32'hffff_ff80) begin errors++; $display("FAIL lb_signed got=%h exp=ffffff80", rd); end
    model(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, erd, eer, elat, ewe, ewd);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, rd, er, wec, wds);
    checks++; if (rd !== 32'h0000_0080) begin errors++; $display("FAIL lb_unsigned got=%h exp=00000080", rd); end
    model(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_f00d, erd, eer, elat, ewe, ewd);
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_f00d, lat, rd, er, wec, wds);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wstore_lat got=%0d exp=2", lat); end
    checks++; if (wds !== 32'h1122_f00d || wec !== 1) begin
      errors++; $display("FAIL wstore_wd got=%h/%0d exp=1122f00d/1", wds, wec);
    end
    model(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, erd, eer, elat, ewe, ewd);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, rd, er, wec, wds);
    checks++; if (rd !== 32'hffff_f00d) begin errors++; $display("FAIL lh_signed got=%h exp=fffff00d", rd); end
  endtask

  task automatic test_errors();
    logic        t_we   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0]  t_size [4] = '{2'b01, 2'b10, 2'b10, 2'b11};
    logic [31:0] t_addr [4] = '{32'h11, 32'h802, 32'h800, 32'h0};
    int lat, wec; logic [31:0] rd, wds; logic er;
    for (int i = 0; i < 4; i++) begin
      issue(t_we[i], t_size[i], 1'b0, t_addr[i], 32'hdead_beef, lat, rd, er, wec, wds);
      checks++; if (lat !== 1) begin errors++; $display("FAIL err%0d_lat got=%0d exp=1", i, lat); end
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL err%0d_flag got=%b exp=1", i, er); end
      checks++; if (wec !== 0) begin errors++; $display("FAIL err%0d_we got=%0d exp=0", i, wec); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err%0d_rdata got=%h exp=0", i, rd); end
    end
  endtask

  task automatic test_reset_rd2();
    int wec;
    wec = 0;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h10;
    req_wdata = 32'h55; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    if (WE === 1'b1) wec++;
    @(posedge clk); #2;            // now in RD2
    if (WE === 1'b1) wec++;
    rst_n = 1'b0;
    #1;
    checks++; if (WE !== 1'b0 || wec !== 0) begin errors++; $display("FAIL rst_rd2_we got=%b/%0d exp=0/0", WE, wec); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_rd2_ready got=%b exp=1", req_ready); end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (mem[4] !== ref_mem[4]) begin errors++; $display("FAIL rst_rd2_mem got=%h exp=%h", mem[4], ref_mem[4]); end
  endtask

  task automatic test_reset_wr();
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h20;
    req_wdata = 32'hdead_beef; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    #2;
    checks++; if (WE !== 1'b1) begin errors++; $display("FAIL rst_wr_we_hi got=%b exp=1", WE); end
    rst_n = 1'b0;
    #1;                            // well before the next rising edge
    checks++; if (WE !== 1'b0) begin errors++; $display("FAIL rst_wr_we_drop got=%b exp=0", WE); end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (mem[8] !== ref_mem[8]) begin errors++; $display("FAIL rst_wr_mem got=%h exp=%h", mem[8], ref_mem[8]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] data [3] = '{32'ha1a1_0001, 32'hb2b2_0002, 32'hc3c3_0003};
    int acc_cyc [3];
    int n, low, elat, ewe;
    logic accepted;
    logic [31:0] erd, ewd; logic eer;
    n = 0; low = 0;
    for (int i = 0; i < 3; i++) begin
      acc_cyc[i] = 0;
      model(1'b1, 2'b10, 1'b0, 32'(4 * i), data[i], erd, eer, elat, ewe, ewd);
    end
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h0;
    req_wdata = data[0]; req_valid = 1'b1;
    for (int c = 0; c < 20 && n < 3; c++) begin
      accepted = req_ready;
      if (accepted) acc_cyc[n] = c;
      else if (n > 0) low++;
      @(posedge clk); #1;
      if (accepted) begin
        n++;
        if (n < 3) begin
          req_addr = 32'(4 * n); req_wdata = data[n];
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", n); end
    checks++; if (acc_cyc[1] - acc_cyc[0] !== 3) begin
      errors++; $display("FAIL b2b_gap0 got=%0d exp=3", acc_cyc[1] - acc_cyc[0]);
    end
    checks++; if (acc_cyc[2] - acc_cyc[1] !== 3) begin
      errors++; $display("FAIL b2b_gap1 got=%0d exp=3", acc_cyc[2] - acc_cyc[1]);
    end
    checks++; if (low !== 4) begin errors++; $display("FAIL b2b_ready_low got=%0d exp=4", low); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem[i] !== data[i]) begin errors++; $display("FAIL b2b_mem%0d got=%h exp=%h", i, mem[i], data[i]); end
    end
  endtask

  task automatic test_random();
    int lat, wec, elat, ewe; logic [31:0] rd, wds, erd, ewd; logic er, eer;
    logic we, uns; logic [1:0] size; logic [31:0] addr, wdata;
    for (int i = 0; i < 120; i++) begin
      we    = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      size  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr  = ($urandom_range(0, 9) == 0) ? 32'h800 + 32'($urandom_range(0, 63))
                                          : 32'($urandom_range(0, 63));
      wdata = $urandom;
      model(we, size, uns, addr, wdata, erd, eer, elat, ewe, ewd);
      issue(we, size, uns, addr, wdata, lat, rd, er, wec, wds);
      checks++;
      if (lat !== elat || er !== eer || rd !== erd || wec !== ewe || (ewe == 1 && wds !== ewd)) begin
        errors++;
        $display("FAIL rand%0d we=%b sz=%0d u=%b a=%h d=%h got lat=%0d err=%b rd=%h we=%0d wd=%h exp lat=%0d err=%b rd=%h we=%0d wd=%h",
                 i, we, size, uns, addr, wdata, lat, er, rd, wec, wds, elat, eer, erd, ewe, ewd);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int i = 0; i < 16; i++) begin
      checks++; if (mem[i] !== ref_mem[i]) begin errors++; $display("FAIL rand_mem%0d got=%h exp=%h", i, mem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    bd_clear = 1'b0; bd_we = 1'b0; bd_idx = 9'h0; bd_data = 32'h0;
    test_reset();
    test_word_load();
    test_byte_store();
    test_sign_ext();
    test_errors();
    test_reset_rd2();
    test_reset_wr();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
